tile_window_loader: RTL

TILE_WINDOW_LOADER -- requirements
Module: tile_window_loader

---
 rtl/tile_window_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tile_window_loader.sv
// Tile window loader: buffers one TILE_W x TILE_H tile delivered LANES pixels
// per beat, then streams 3x3 neighbourhoods in raster order of their centres,
// optionally replicating border pixels so every tile pixel becomes a centre.
module tile_window_loader #(
  parameter int BIT_LENGTH = 4,
  parameter int LANES      = 5,
  parameter int TILE_W     = 20,
  parameter int TILE_H     = 20,
  parameter int PAD        = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES*BIT_LENGTH-1:0]   pixel_in,
  input  logic                          in_valid,
  input  logic                          load_end,
  output logic                          in_ready,
  output logic [9*BIT_LENGTH-1:0]       win_out,
  output logic [$clog2(TILE_H)-1:0]     win_row,
  output logic [$clog2(TILE_W)-1:0]     win_col,
  output logic                          readable,
  input  logic                          out_ready,
  output logic                          tile_done,
  output logic                          tile_err
);

  localparam int NPIX  = TILE_W * TILE_H;
  localparam int BEATS = NPIX / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(NPIX);
  localparam int RW    = $clog2(TILE_H);
  localparam int CW    = $clog2(TILE_W);

  // Centre ranges: without padding the outermost ring cannot be a centre.
  localparam logic [RW-1:0] ROW_FIRST = RW'((PAD != 0) ? 0 : 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'((PAD != 0) ? TILE_H - 1 : TILE_H - 2);
  localparam logic [CW-1:0] COL_FIRST = CW'((PAD != 0) ? 0 : 1);
  localparam logic [CW-1:0] COL_LAST  = CW'((PAD != 0) ? TILE_W - 1 : TILE_W - 2);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t                 state, state_nxt;
  logic [BW-1:0]          beat_cnt;
  logic [BW-1:0]          cur_beat;
  logic [RW-1:0]          row;
  logic [CW-1:0]          col;
  logic [BIT_LENGTH-1:0]  mem [NPIX];
  logic                   accept;
  logic                   final_beat;
  logic                   err_now;
  logic                   win_take;
  logic                   last_win;
  logic [9*BIT_LENGTH-1:0] win_raw;

  // Neighbour coordinates outside the tile snap to the nearest edge.
  function automatic int clamp(input int v, input int hi);
    if (v < 0)       return 0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // The beat being offered is number 0 while idle, otherwise the running count.
  assign cur_beat   = (state == IDLE) ? '0 : beat_cnt;
  assign final_beat = (cur_beat == BW'(BEATS - 1));
  // A missing load_end on the final beat and an early load_end are both errors.
  assign err_now    = final_beat ? ~load_end : load_end;
  assign last_win   = (row == ROW_LAST) && (col == COL_LAST);
  assign readable   = (state == STREAM);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    win_take  = 1'b0;
    case (state)
      IDLE, LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          if (final_beat)    state_nxt = STREAM;
          else if (load_end) state_nxt = IDLE;
          else               state_nxt = LOAD;
        end
      end
      STREAM: begin
        win_take = out_ready;
        if (out_ready && last_win) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter, error flag, done pulse and window centre counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt  <= '0;
      tile_err  <= 1'b0;
      tile_done <= 1'b0;
      row       <= '0;
      col       <= '0;
    end else begin
      tile_done <= win_take && last_win;
      if (accept) begin
        if (final_beat || load_end) beat_cnt <= '0;
        else                        beat_cnt <= cur_beat + 1'b1;
        // The first beat of a new tile starts with a clean error flag.
        tile_err <= ((state == IDLE) ? 1'b0 : tile_err) | err_now;
        if (final_beat) begin
          row <= ROW_FIRST;
          col <= COL_FIRST;
        end
      end
      if (win_take) begin
        if (col == COL_LAST) begin
          col <= COL_FIRST;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Tile storage: lane l of beat k lands at raster index k*LANES+l; never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < LANES; l++) begin
        mem[AW'(int'(cur_beat) * LANES + l)] <= pixel_in[l*BIT_LENGTH +: BIT_LENGTH];
      end
    end
  end

  // Gather the 3x3 neighbourhood around the current centre, row-major.
  always_comb begin
    win_raw = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        win_raw[(dr*3 + dc)*BIT_LENGTH +: BIT_LENGTH] =
          mem[AW'(clamp(int'(row) + dr - 1, TILE_H - 1) * TILE_W +
                  clamp(int'(col) + dc - 1, TILE_W - 1))];
      end
    end
  end

  // Window outputs read as zero whenever no window is being offered.
  always_comb begin
    win_out = '0;
    win_row = '0;
    win_col = '0;
    if (readable) begin
      win_out = win_raw;
      win_row = row;
      win_col = col;
    end
  end

endmodule
